// File: rtl/binary_mul_seq_n.sv
// binary_mul_seq_n: shift-add sequential multiplier, signed or unsigned per op.
// Processes one multiplier bit per enabled cycle and produces a full 2*WIDTH product.
// With en held high the product is ready WIDTH cycles after the operands are accepted.
module binary_mul_seq_n #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;    // extended multiplicand, pre-shifted to the current bit weight
    logic [WIDTH-1:0] mplier;  // multiplier, shifted right so bit 0 is the current bit
    logic            sgn;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   term;
    logic [PW-1:0]   acc_nxt;
    logic            last;

    // Ready is a pure decode of the state register, so there is no input-to-output path.
    assign in_ready = (state == IDLE);
    assign last     = (cnt == CW'(WIDTH - 1));

    // Partial product for the current bit; the signed MSB carries negative weight.
    always_comb begin
        term    = mplier[0] ? mcand : '0;
        acc_nxt = (sgn && last) ? (acc - term) : (acc + term);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            sgn       <= 1'b0;
            cnt       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{is_signed & a[WIDTH-1]}}, a};
                        mplier <= b;
                        sgn    <= is_signed;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            p         <= acc_nxt;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_binary_mul_seq_n.sv
// Bench for binary_mul_seq_n: directed corner cases plus randomized ops at WIDTH=4,
// and a WIDTH=8 instance, all checked against an integer-arithmetic product model.
module tb_binary_mul_seq_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // WIDTH=4 instance
    logic       en = 1'b1, in_valid = 1'b0, in_ready, is_signed = 1'b0;
    logic       out_valid, out_ready = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic [7:0] p;

    // WIDTH=8 instance
    logic        en8 = 1'b1, in_valid8 = 1'b0, in_ready8, is_signed8 = 1'b0;
    logic        out_valid8, out_ready8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    int passed = 0;
    int total  = 0;

    binary_mul_seq_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .p(p)
    );

    binary_mul_seq_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(is_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .p(p8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y, input logic s);
        int xi, yi;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        return 8'(xi * yi);
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi, yi;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        return 16'(xi * yi);
    endfunction

    // One WIDTH=4 op starting at a negedge with the block idle. en is dropped for
    // `stall` cycles right after the first processed bit; out_ready is held low
    // for `hold` cycles once the product is up.
    task automatic op4(input logic [3:0] aa, input logic [3:0] bb, input logic s,
                       input int stall, input int hold);
        logic [7:0] exp;
        int lat;
        exp = model4(aa, bb, s);
        chk("idle_ready", in_ready, 1);
        a = aa; b = bb; is_signed = s; in_valid = 1'b1; en = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("run_not_ready", in_ready, 0);
        // operands are latched; wiggling them must not matter
        a = 4'($urandom); b = 4'($urandom); is_signed = ~s;
        lat = 0;
        while (!out_valid && lat < 64) begin
            en = !(lat >= 1 && lat < 1 + stall);
            @(negedge clk);
            lat++;
        end
        en = 1'b1;
        chk("latency", 32'(lat), 32'(4 + stall));
        chk("product", p, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_p", p, exp);
            chk("hold_not_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_ready", in_ready, 1);
        chk("post_hs_p", p, exp);
    endtask

    task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic s);
        int lat;
        a8 = aa; b8 = bb; is_signed8 = s; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_latency", 32'(lat), 8);
        chk("w8_product", p8, model8(aa, bb, s));
        @(negedge clk);
        out_ready8 = 1'b0;
        chk("w8_post_ready", in_ready8, 1);
    endtask

    initial begin
        logic [7:0] expq[$];
        logic [7:0] e;
        int last_acc, cyc, nacc;

        #12;
        chk("rst_p", p, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed corners
        op4(4'h8, 4'h8, 1'b1, 0, 0);   // -8 * -8 = 64
        chk("neg_neg", p, 8'h40);
        op4(4'h7, 4'hD, 1'b1, 0, 0);   // 7 * -3 = -21
        chk("pos_neg", p, 8'hEB);
        op4(4'hF, 4'hF, 1'b0, 0, 0);   // 225
        chk("unsigned_max", p, 8'hE1);
        op4(4'h5, 4'h6, 1'b1, 3, 5);   // stall + backpressure
        op8(8'h80, 8'h7F, 1'b1);
        chk("w8_signed", p8, 16'hC080);
        op8(8'hFF, 8'hFF, 1'b0);
        chk("w8_unsigned", p8, 16'hFE01);

        // randomized ops with random stalls and backpressure
        for (int n = 0; n < 30; n++)
            op4(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        for (int n = 0; n < 10; n++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));

        // back-to-back with in_valid and out_ready tied high
        in_valid = 1'b1; out_ready = 1'b1; en = 1'b1;
        last_acc = -1; nacc = 0;
        for (cyc = 0; cyc < 80; cyc++) begin
            if (out_valid) begin
                if (expq.size() == 0) chk("b2b_unexpected", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("b2b_product", p, e);
                end
            end
            if (in_ready) begin
                if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 6);
                last_acc = cyc;
                nacc++;
                a = 4'($urandom); b = 4'($urandom); is_signed = 1'($urandom);
                expq.push_back(model4(a, b, is_signed));
            end
            @(negedge clk);
        end
        chk("b2b_count", 32'(nacc), 14);
        // drain the last operation
        in_valid = 1'b0;
        cyc = 0;
        while (expq.size() > 0 && cyc < 20) begin
            if (out_valid) begin
                e = expq.pop_front();
                chk("b2b_drain", p, e);
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_drained", 32'(expq.size()), 0);
        out_ready = 1'b0;
        @(negedge clk);

        // reset asserted mid-RUN
        a = 4'h3; b = 4'h5; is_signed = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_p", p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("aborted_no_valid", out_valid, 0);
        end
        op4(4'h9, 4'h3, 1'b1, 0, 0);   // -7 * 3 = -21
        chk("after_rst", p, 8'hEB);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
